// File: rtl/tank_pump_controller.sv
// Fill-pump sequencer: synchronized/debounced level sensors, LED drive, rest and timeout protection.
// Optional build macro PUMP_RUN_COUNT_EN adds a saturating 16-bit fill counter output (run_count).
module tank_pump_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_REST_CYCLES = 8,
    parameter int unsigned FILL_TIMEOUT    = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        low_sensor,
    input  logic        high_sensor,
    input  logic        fault_clear,
    output logic        pump_on,
    output logic        led_full,
    output logic        led_low,
    output logic        fault,
`ifdef PUMP_RUN_COUNT_EN
    output logic [15:0] run_count,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_REST  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(MIN_REST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [1:0]       low_sync_q, low_sync_d, high_sync_q, high_sync_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
    logic             low_filt_q, low_filt_d, high_filt_q, high_filt_d;
    logic             led_full_q, led_full_d, led_low_q, led_low_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] fill_tmr_q, fill_tmr_d, rest_tmr_q, rest_tmr_d;
    logic             pump_on_q, pump_on_d, fault_q, fault_d;
    logic             inconsistent_s;

    // Synchronizer shift and debounce: filtered value moves only after DEBOUNCE_CYCLES disagreeing cycles
    always_comb begin
        low_sync_d  = {low_sync_q[0], low_sensor};
        high_sync_d = {high_sync_q[0], high_sensor};
        low_filt_d  = low_filt_q;
        low_cnt_d   = low_cnt_q;
        high_filt_d = high_filt_q;
        high_cnt_d  = high_cnt_q;

        if (low_sync_q[1] == low_filt_q) begin
            low_cnt_d = CNT_ZERO;
        end else if (low_cnt_q >= DEB_LAST) begin
            low_filt_d = low_sync_q[1];
            low_cnt_d  = CNT_ZERO;
        end else begin
            low_cnt_d = sat_inc(low_cnt_q);
        end

        if (high_sync_q[1] == high_filt_q) begin
            high_cnt_d = CNT_ZERO;
        end else if (high_cnt_q >= DEB_LAST) begin
            high_filt_d = high_sync_q[1];
            high_cnt_d  = CNT_ZERO;
        end else begin
            high_cnt_d = sat_inc(high_cnt_q);
        end

        led_full_d = high_filt_q;
        led_low_d  = ~low_filt_q;
    end

    assign inconsistent_s = high_filt_q & ~low_filt_q;

    // Pump sequencing; a high-without-low reading overrides every other transition
    always_comb begin
        state_d    = state_q;
        fill_tmr_d = fill_tmr_q;
        rest_tmr_d = rest_tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (inconsistent_s) begin
                    state_d = ST_FAULT;
                end else if (enable && !low_filt_q) begin
                    state_d    = ST_FILL;
                    fill_tmr_d = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                fill_tmr_d = sat_inc(fill_tmr_q);
                if (inconsistent_s) begin
                    state_d = ST_FAULT;
                end else if (high_filt_q || !enable) begin
                    state_d    = ST_REST;
                    rest_tmr_d = CNT_ZERO;
                end else if (fill_tmr_q >= FILL_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_REST: begin
                rest_tmr_d = sat_inc(rest_tmr_q);
                if (inconsistent_s) begin
                    state_d = ST_FAULT;
                end else if (rest_tmr_q >= REST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REST;
                end
            end
            ST_FAULT: begin
                if (fault_clear && !inconsistent_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pump_on_d = (state_d == ST_FILL);
        fault_d   = (state_d == ST_FAULT);
    end

    // Sensor path registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            low_sync_q  <= 2'b00;
            high_sync_q <= 2'b00;
            low_cnt_q   <= CNT_ZERO;
            high_cnt_q  <= CNT_ZERO;
            low_filt_q  <= 1'b0;
            high_filt_q <= 1'b0;
            led_full_q  <= 1'b0;
            led_low_q   <= 1'b0;
        end else begin
            low_sync_q  <= low_sync_d;
            high_sync_q <= high_sync_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            low_filt_q  <= low_filt_d;
            high_filt_q <= high_filt_d;
            led_full_q  <= led_full_d;
            led_low_q   <= led_low_d;
        end
    end

    // FSM state, timers and registered pump/fault outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fill_tmr_q <= CNT_ZERO;
            rest_tmr_q <= CNT_ZERO;
            pump_on_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_tmr_q <= fill_tmr_d;
            rest_tmr_q <= rest_tmr_d;
            pump_on_q  <= pump_on_d;
            fault_q    <= fault_d;
        end
    end

`ifdef PUMP_RUN_COUNT_EN
    logic [15:0] run_count_q, run_count_d;

    // Count fill starts, holding at full scale
    always_comb begin
        if ((state_q == ST_IDLE) && (state_d == ST_FILL) && (run_count_q != 16'hFFFF)) begin
            run_count_d = run_count_q + 16'd1;
        end else begin
            run_count_d = run_count_q;
        end
    end

    // Fill counter register; only reset clears it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_count_q <= 16'd0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

    assign run_count = run_count_q;
`endif

    assign pump_on  = pump_on_q;
    assign led_full = led_full_q;
    assign led_low  = led_low_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: doc/tank_pump_controller.md
Name: tank_pump_controller

Overview:
- Closes the loop around the tank level indicator: takes raw low/high level sensors, filters them, and sequences a fill pump.
- Drives the full/low LEDs from filtered levels, so the indicator path and the pump decision see identical sensor values.
- Enforces a minimum rest time between fills (anti-short-cycling) and a fill timeout (dry-run/leak protection) with a latched fault.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a filtered sensor value changes (>=1)
- MIN_REST_CYCLES, 8, cycles the pump is held off after any fill ends (>=1)
- FILL_TIMEOUT, 64, maximum cycles in FILL before a fault is raised (>=2)
- CNT_W, 8, width of the internal timers; must hold max(DEBOUNCE_CYCLES, MIN_REST_CYCLES, FILL_TIMEOUT)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = automatic filling permitted
- low_sensor  in  1  raw, asynchronous; 1 = water at low mark
- high_sensor  in  1  raw, asynchronous; 1 = water at high mark
- fault_clear  in  1  single-cycle pulse; acknowledges a latched fault
- pump_on  out  1  pump drive, registered
- led_full  out  1  filtered high level, registered
- led_low  out  1  inverse of filtered low level, registered
- fault  out  1  latched fault flag, registered
- state  out  2  FSM state: 00 IDLE, 01 FILL, 10 REST, 11 FAULT

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, state=IDLE, timers 0, synchronizers 0, filtered sensors 0.
- Each sensor passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: counter clears whenever the synced value equals the filtered value. Otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1 the filtered value takes the synced value.
- Input-to-filtered latency: 2+DEBOUNCE_CYCLES cycles; the LED outputs follow one cycle later.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the filtered value.
- Inconsistent condition: filtered high=1 and filtered low=0. From IDLE, FILL or REST it forces FAULT on the next edge, with priority over all other transitions.
- IDLE: pump_on=0.
  - If enable=1 and filtered low=0, go to FILL and clear the fill timer.
- FILL: pump_on=1; the fill timer increments every cycle.
  - Filtered high=1: go to REST and clear the rest timer.
  - Otherwise, enable=0: go to REST (same rest timer clear).
  - Otherwise, fill timer = FILL_TIMEOUT-1: go to FAULT.
  - High wins over timeout in the same cycle.
- REST: pump_on=0; the rest timer increments.
  - At MIN_REST_CYCLES-1, go to IDLE.
  - enable toggling in REST has no effect.
- FAULT: pump_on=0, fault=1.
  - Leave to IDLE only when fault_clear=1 and the inconsistent condition is false; otherwise stay in FAULT.
  - fault_clear outside FAULT is ignored.
- pump_on, fault and state are registered, and are valid in the cycle after the state register updates.
- Timers saturate and never wrap.
- Reset asserted mid-FILL drops pump_on immediately (asynchronously).

Optional Feature:
- Macro PUMP_RUN_COUNT_EN.
- Defined:
  - Adds output run_count [15:0], reset to 0.
  - Increments on every IDLE->FILL transition and saturates at 16'hFFFF.
  - fault_clear does not reset it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then enable=1, low_sensor=0, high_sensor=0 -> state goes IDLE->FILL and pump_on=1 within 2+4+2 cycles; led_low=1, led_full=0.
- In FILL, raise low_sensor=1, then high_sensor=1 after 10 cycles -> pump_on=0 and state=REST about 7 cycles after high rises; IDLE exactly 8 cycles later; led_full=1.
- Pulse high_sensor=1 for 3 cycles while filling -> filtered high unchanged, pump_on stays 1, led_full stays 0.
- Hold low=0, high=0, enable=1 -> after 64 cycles in FILL, state=FAULT, fault=1, pump_on=0. Pulse fault_clear -> IDLE, then FILL again.
- Drive high_sensor=1 with low_sensor=0 from IDLE -> FAULT. fault_clear while the condition persists -> stays FAULT. Fix the sensors and pulse fault_clear again -> IDLE.
- Assert reset_n=0 mid-FILL -> pump_on=0 without waiting for a clock edge. With PUMP_RUN_COUNT_EN defined, three completed fills -> run_count=3.
